fp_normalize_pack: RTL and testbench
====================================

// Module: fp_normalize_pack
// PURPOSE
//  Post-add stage of the double-precision datapath. Accepts the raw 53-bit signed-magnitude
//  mantissa result (sum, carry, sign) from the mantissa adder together with the aligned exponent.
//  Normalises it with a sequential one-bit-per-cycle shifter and packs it into an IEEE-754 word.
//  Sits between the mantissa adder output and the result register / display logic.
// PARAMETERS
//  EXP_W   11  exponent field width
//  MAN_W   53  mantissa width incl. hidden bit (fraction = MAN_W-1)
// PORTS
//  clk       in   1              rising-edge clock
//  rst       in   1              asynchronous reset, ACTIVE-LOW
//  en        in   1              1 = FSM advances; 0 = all state and outputs hold
//  in_valid  in   1              input word present (driven from the adder's ready)
//  sum       in   MAN_W          unsigned mantissa magnitude
//  c_out     in   1              carry out of the mantissa add
//  sign      in   1              result sign
//  exp_in    in   EXP_W          common (larger) biased exponent of the operands
//  result    out  1+EXP_W+MAN_W-1  packed {sign, exp, frac}
//  done      out  1              one-cycle pulse: result updated this cycle
//  busy      out  1              1 while not IDLE; in_valid is ignored while busy
//  overflow  out  1              result saturated to +/-infinity (valid with done)
//  zero      out  1              result is +0 (valid with done)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; result, done, busy, overflow, zero all 0; internal regs 0.
//  States: IDLE -> NORM -> PACK -> IDLE.
//  IDLE: on en & in_valid, capture sum/c_out/sign/exp_in into m, c, s, e.
//    exp_in==0 is captured as e=1 (denormal input). Go to NORM; busy=1 from next cycle.
//  NORM, one action per cycle (each action counts as one shift, k):
//    c=1: m={1'b1,m[MAN_W-1:1]}, e=e+1, c=0 (dropped LSB truncated: round toward zero).
//    else m==0: go PACK as zero case.
//    else m[MSB]==0 and e>1: m=m<<1, e=e-1.
//    else go PACK (normalised, or denormal when m[MSB]==0 and e==1).
//  PACK: go to IDLE and register outputs in the same cycle.
//    zero case: result=all-zero (sign forced 0), zero=1.
//    e >= 2^EXP_W-1: result={s,all-ones exp,0 frac}, overflow=1.
//    m[MSB]==0 (denormal): exp field=0, frac=m[MAN_W-2:0].
//    otherwise: {s,e,m[MAN_W-2:0]}.
//    done=1 for exactly that one cycle.
//  Latency: in_valid sampled at edge E0; done/result visible after edge E0+2+k.
//    k=0 if already normal or zero; worst case k=MAN_W-1.
//  result, overflow, zero hold until the next done; overflow/zero are cleared on a done that does not set them.
//  en=0 in any state freezes everything. A done pulse pending in PACK is emitted only when en returns.
//  in_valid during busy (including the PACK cycle) is dropped; no queueing.
//  Reset mid-operation aborts to IDLE. No done is produced for the aborted word.
//  Exponent arithmetic uses EXP_W+1 bits internally, so the e+1 carry is detected, not wrapped.
// TESTING
//  1) sum=53'h10000000000000,c_out=0,sign=0,exp_in=11'h3FF -> result=64'h3FF0000000000000, done after E0+2.
//  2) sum=0,c_out=1,sign=0,exp_in=11'h3FF (1+1) -> 64'h4000000000000000, k=1, done after E0+3.
//  3) sum=53'h08000000000000,exp_in=11'h3FF,sign=1 -> 64'hBFE0000000000000 (-0.5), k=1.
//  4) sum=0,c_out=0,sign=1 -> 64'h0 (zero=1); then exp_in=11'h7FE,c_out=1,sign=1 -> 64'hFFF0000000000000, overflow=1.
//  5) sum=53'h08000000000000,exp_in=11'h001 -> 64'h0008000000000000 (denormal); sum=1,exp_in=11'h3FF -> k=52, 64'h3CB0000000000000.
//  6) Stress: sum=1 starts a long shift; drop en 5 cycles -> state frozen, no done; pulse rst low mid-NORM -> IDLE, no done;
//     in_valid pulses while busy -> ignored.

Source files
------------

// File: rtl/fp_normalize_pack.sv
// Post-add normaliser: one-bit-per-cycle shifter that turns a signed-magnitude mantissa
// sum into a packed IEEE-754 word, saturating to infinity and flushing to +0.
module fp_normalize_pack #(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 53
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic                   in_valid_i,
  input  logic [MAN_W-1:0]       sum_i,
  input  logic                   c_out_i,
  input  logic                   sign_i,
  input  logic [EXP_W-1:0]       exp_in_i,
  output logic [EXP_W+MAN_W-1:0] result_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  output logic                   zero_o
);

  localparam int unsigned ResW = EXP_W + MAN_W;
  // Exponent carries one spare bit so the e+1 from a mantissa carry is seen, not wrapped.
  localparam logic [EXP_W:0] ExpOne = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] ExpMax = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StNorm, StPack} state_e;

  state_e            state_q, state_d;
  logic [MAN_W-1:0]  m_q, m_d;
  logic [EXP_W:0]    e_q, e_d;
  logic              c_q, c_d;
  logic              s_q, s_d;
  logic              zc_q, zc_d;
  logic [ResW-1:0]   result_q, result_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              zero_q, zero_d;

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    e_d        = e_q;
    c_d        = c_q;
    s_d        = s_q;
    zc_d       = zc_q;
    result_d   = result_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    zero_d     = zero_q;
    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          m_d     = sum_i;
          c_d     = c_out_i;
          s_d     = sign_i;
          e_d     = (exp_in_i == '0) ? ExpOne : {1'b0, exp_in_i};
          zc_d    = 1'b0;
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (c_q) begin
          // Dropped LSB is truncated (round toward zero).
          m_d = {1'b1, m_q[MAN_W-1:1]};
          e_d = e_q + ExpOne;
          c_d = 1'b0;
        end else if (m_q == '0) begin
          zc_d    = 1'b1;
          state_d = StPack;
        end else if (!m_q[MAN_W-1] && (e_q > ExpOne)) begin
          m_d = m_q << 1;
          e_d = e_q - ExpOne;
        end else begin
          state_d = StPack;
        end
      end
      StPack: begin
        state_d    = StIdle;
        done_d     = 1'b1;
        overflow_d = 1'b0;
        zero_d     = 1'b0;
        if (zc_q) begin
          result_d = '0;
          zero_d   = 1'b1;
        end else if (e_q >= ExpMax) begin
          result_d   = {s_q, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
          overflow_d = 1'b1;
        end else if (!m_q[MAN_W-1]) begin
          result_d = {s_q, {EXP_W{1'b0}}, m_q[MAN_W-2:0]};
        end else begin
          result_d = {s_q, e_q[EXP_W-1:0], m_q[MAN_W-2:0]};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      m_q        <= '0;
      e_q        <= '0;
      c_q        <= 1'b0;
      s_q        <= 1'b0;
      zc_q       <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else if (en_i) begin
      state_q    <= state_d;
      m_q        <= m_d;
      e_q        <= e_d;
      c_q        <= c_d;
      s_q        <= s_d;
      zc_q       <= zc_d;
      result_q   <= result_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign result_o   = result_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != StIdle);
  assign overflow_o = overflow_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: expected word, flags and latency are queued at
// issue and compared whenever done is seen.
module tb_fp_normalize_pack;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic [52:0] sum_i = '0;
  logic        c_out_i = 1'b0;
  logic        sign_i = 1'b0;
  logic [10:0] exp_in_i = '0;
  logic [63:0] result_o;
  logic        done_o, busy_o, overflow_o, zero_o;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    logic        zr;
    int          lat;
    int          e0;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fp_normalize_pack #(.EXP_W(11), .MAN_W(53)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .in_valid_i (in_valid_i),
    .sum_i      (sum_i),
    .c_out_i    (c_out_i),
    .sign_i     (sign_i),
    .exp_in_i   (exp_in_i),
    .result_o   (result_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .overflow_o (overflow_o),
    .zero_o     (zero_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference: apply the carry once, else shift left until normal or e reaches 1.
  function automatic exp_t model(input logic [52:0] sm, input logic c, input logic sg,
                                 input logic [10:0] ex);
    exp_t r;
    logic [52:0] m;
    int e, k;
    m = sm;
    e = (ex == 0) ? 1 : int'(ex);
    k = 0;
    r.ovf = 1'b0;
    r.zr  = 1'b0;
    if (c) begin
      m = {1'b1, m[52:1]};
      e = e + 1;
      k = 1;
    end else if (m != 0) begin
      while (!m[52] && e > 1) begin
        m = m << 1;
        e = e - 1;
        k = k + 1;
      end
    end
    if (!c && sm == 0) begin
      r.res = 64'h0;
      r.zr  = 1'b1;
    end else if (e >= 2047) begin
      r.res = {sg, 11'h7FF, 52'h0};
      r.ovf = 1'b1;
    end else if (!m[52]) begin
      r.res = {sg, 11'h000, m[51:0]};
    end else begin
      r.res = {sg, 11'(e), m[51:0]};
    end
    r.lat = 2 + k;
    r.e0  = 0;
    return r;
  endfunction

  always @(posedge clk_i) begin
    exp_t x;
    #1;
    if (done_o) begin
      if (q.size() == 0) begin
        check_val("spurious_done", 64'(done_o), 64'h0);
      end else begin
        x = q.pop_front();
        check_val("result", result_o, x.res);
        check_val("overflow", 64'(overflow_o), 64'(x.ovf));
        check_val("zero", 64'(zero_o), 64'(x.zr));
        check_val("latency", 64'(cyc - x.e0), 64'(x.lat));
      end
    end
  end

  task automatic send(input logic [52:0] sm, input logic c, input logic sg,
                      input logic [10:0] ex, input int extra, input bit track);
    exp_t x;
    @(negedge clk_i);
    in_valid_i = 1'b1;
    sum_i      = sm;
    c_out_i    = c;
    sign_i     = sg;
    exp_in_i   = ex;
    @(posedge clk_i);
    #1;
    if (track) begin
      x     = model(sm, c, sg, ex);
      x.lat = x.lat + extra;
      x.e0  = cyc;
      q.push_back(x);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy_o) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check_val("drain", 64'(q.size()), 64'h0);
    q.delete();
  endtask

  initial begin
    #3;
    check_val("rst_result", result_o, 64'h0);
    check_val("rst_done", 64'(done_o), 64'h0);
    check_val("rst_busy", 64'(busy_o), 64'h0);
    check_val("rst_flags", 64'({overflow_o, zero_o}), 64'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    send(53'h10000000000000, 1'b0, 1'b0, 11'h3FF, 0, 1'b1); wait_idle();
    check_val("t1_const", result_o, 64'h3FF0000000000000);
    send(53'h0, 1'b1, 1'b0, 11'h3FF, 0, 1'b1); wait_idle();
    check_val("t2_const", result_o, 64'h4000000000000000);
    send(53'h08000000000000, 1'b0, 1'b1, 11'h3FF, 0, 1'b1); wait_idle();
    check_val("t3_const", result_o, 64'hBFE0000000000000);
    send(53'h0, 1'b0, 1'b1, 11'h3FF, 0, 1'b1); wait_idle();
    check_val("t4_zero", 64'({zero_o, result_o[63]}), 64'h2);
    send(53'h0, 1'b1, 1'b1, 11'h7FE, 0, 1'b1); wait_idle();
    check_val("t4_inf", result_o, 64'hFFF0000000000000);
    send(53'h08000000000000, 1'b0, 1'b0, 11'h001, 0, 1'b1); wait_idle();
    check_val("t5_denorm", result_o, 64'h0008000000000000);
    send(53'h1, 1'b0, 1'b0, 11'h3FF, 0, 1'b1); wait_idle();
    check_val("t5_long", result_o, 64'h3CB0000000000000);
    send(53'h3, 1'b0, 1'b0, 11'h000, 0, 1'b1); wait_idle();
    send(53'h1FFFFFFFFFFFFF, 1'b1, 1'b0, 11'h7FF, 0, 1'b1); wait_idle();

    for (int i = 0; i < 10; i++) begin
      logic [52:0] r;
      logic [10:0] ex;
      r  = {$urandom, $urandom} >> $urandom_range(0, 53);
      ex = (i % 4 == 0) ? 11'($urandom_range(0, 40)) : 11'($urandom);
      send(r, ($urandom_range(0, 3) == 0), 1'($urandom), ex, 0, 1'b1);
      wait_idle();
    end

    // en freeze mid-NORM adds exactly the frozen cycles to latency.
    send(53'h1, 1'b0, 1'b1, 11'h3FF, 5, 1'b1);
    repeat (10) @(negedge clk_i);
    en_i = 1'b0;
    repeat (5) @(negedge clk_i);
    check_val("frozen_busy", 64'(busy_o), 64'h1);
    en_i = 1'b1;
    wait_idle();

    // Reset mid-NORM aborts with no done.
    send(53'h1, 1'b0, 1'b0, 11'h3FF, 0, 1'b0);
    repeat (10) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_val("abort_busy", 64'(busy_o), 64'h0);
    check_val("abort_result", result_o, 64'h0);
    #2;
    rst_ni = 1'b1;
    repeat (70) @(negedge clk_i);

    // in_valid held while busy, through the PACK cycle, must be dropped.
    send(53'h1, 1'b0, 1'b0, 11'h3FF, 0, 1'b1);
    in_valid_i = 1'b1;
    sum_i      = 53'h0;
    c_out_i    = 1'b1;
    exp_in_i   = 11'h7FE;
    for (int n = 0; n < 200 && busy_o; n++) @(negedge clk_i);
    in_valid_i = 1'b0;
    wait_idle();
    check_val("drop_result", result_o, 64'h3CB0000000000000);
    repeat (5) @(negedge clk_i);
    check_val("drop_idle", 64'(busy_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
